// File: rtl/alu181_sequencer_pkg.sv
// Shared definitions for the ALU181 command sequencer: FSM state encoding,
// settle-counter width and the commonly used ALU181 function selects.
package alu181_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Wide enough for the largest legal settle time (15 cycles).
  localparam int CNT_W = 4;

  // Logic-mode (M=1) selects.
  localparam logic [3:0] SEL_NOTA = 4'b0000;
  localparam logic [3:0] SEL_XOR  = 4'b0110;
  localparam logic [3:0] SEL_AND  = 4'b1011;
  localparam logic [3:0] SEL_OR   = 4'b1110;
  // Arithmetic-mode (M=0) select.
  localparam logic [3:0] SEL_ADD  = 4'b1001;

endpackage

// File: rtl/alu181_sequencer.sv
// Command-side sequencer for a combinational ALU181: registers the ALU inputs,
// waits SETTLE_CYC cycles, captures F and returns it over a valid/ready handshake.
module alu181_sequencer
  import alu181_sequencer_pkg::*;
#(
  parameter int W          = 8,
  parameter int SETTLE_CYC = 2   // legal range 1..15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_m,
  input  logic         cmd_cn,
  input  logic [3:0]   cmd_sel,
  input  logic         cmd_use_acc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_m,
  output logic         alu_cn,
  output logic [3:0]   alu_sel,
  input  logic [W-1:0] alu_f,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_f,
  output logic [W-1:0] acc,
  output logic [7:0]   op_count
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [W-1:0]       alu_a_q,     alu_a_d;
  logic [W-1:0]       alu_b_q,     alu_b_d;
  logic               alu_m_q,     alu_m_d;
  logic               alu_cn_q,    alu_cn_d;
  logic [3:0]         alu_sel_q,   alu_sel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_f_q,     rsp_f_d;
  logic [W-1:0]       acc_q,       acc_d;
  logic [7:0]         op_count_q,  op_count_d;

  // Only combinational output; masked by reset so nothing is accepted while rst is high.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a value unassigned
    // (which would infer a latch); the case below only lists what changes.
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_m_d     = alu_m_q;
    alu_cn_d    = alu_cn_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_f_d     = rsp_f_q;
    acc_d       = acc_q;
    op_count_d  = op_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_a_d   = cmd_use_acc ? acc_q : cmd_a;
          alu_b_d   = cmd_b;
          alu_m_d   = cmd_m;
          alu_cn_d  = cmd_cn;
          alu_sel_d = cmd_sel;
          cnt_d     = CNT_LOAD;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_f_d     = alu_f;
          acc_d       = alu_f;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_m_q     <= 1'b0;
      alu_cn_q    <= 1'b0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_f_q     <= '0;
      acc_q       <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_m_q     <= alu_m_d;
      alu_cn_q    <= alu_cn_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_f_q     <= rsp_f_d;
      acc_q       <= acc_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_m     = alu_m_q;
  assign alu_cn    = alu_cn_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_f_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;

endmodule
